// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM access arbiter.
// Holds state encoding, default widths and port indices.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_MEM   = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester handshake plus RAM control/data lines for the RAM access arbiter.
// slave = arbiter side, master = requesters and RAM side.
interface ram_access_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;

    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [1:0]        grant;

    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_mdatain;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output done0, done1, rdata, busy, grant,
        output ram_read, ram_write, ram_addr, ram_mdatain,
        input  ram_dout
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  done0, done1, rdata, busy, grant,
        input  ram_read, ram_write, ram_addr, ram_mdatain,
        output ram_dout
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way winner select (combinational) with a last-grant pointer updated on completion.
// RR_EN=0 gives fixed priority to port 0; the pointer is still tracked but ignored.
module rr_arbiter2
    import ram_arb_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic [1:0] elig,
    input  logic       upd,
    input  logic       upd_port,
    output logic       win_vld,
    output logic       win_port
);

    logic last;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            last <= PORT_MEM;
        end else if (upd) begin
            last <= upd_port;
        end
    end

    always_comb begin
        win_vld  = |elig;
        win_port = PORT_FETCH;
        if (elig == 2'b10) begin
            win_port = PORT_MEM;
        end else if (elig == 2'b11 && RR_EN != 0) begin
            win_port = ~last;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Arbitrates two requesters onto a 512x32 sync RAM; write done 2 cycles, read done 3 cycles after req sampled.
// Requests are levels held until done; losers stay pending until the arbiter returns to IDLE.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RR_EN  = 1
) (
    input  logic                  Clock,
    input  logic                  Clear,
    ram_access_arbiter_if.slave   bus
);

    state_t            state;
    logic              owner;
    logic              owner_we;
    logic              done0_q;
    logic              done1_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;
    logic [1:0]        grant_q;
    logic              ram_read_q;
    logic              ram_write_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_mdatain_q;

    logic [1:0] elig;
    logic       win_vld;
    logic       win_port;
    logic       complete;
    logic       sel_we;

    // A port seeing done this cycle is dropping req; don't regrant it on stale req.
    assign elig     = {bus.req1 & ~done1_q, bus.req0 & ~done0_q};
    assign complete = (state == CAPTURE) || (state == ISSUE && owner_we);
    assign sel_we   = win_port ? bus.we1 : bus.we0;

    rr_arbiter2 #(.RR_EN(RR_EN)) u_arb (
        .Clock    (Clock),
        .Clear    (Clear),
        .elig     (elig),
        .upd      (complete),
        .upd_port (owner),
        .win_vld  (win_vld),
        .win_port (win_port)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state         <= IDLE;
            owner         <= PORT_FETCH;
            owner_we      <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            rdata_q       <= '0;
            busy_q        <= 1'b0;
            grant_q       <= 2'b00;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_mdatain_q <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner         <= win_port;
                        owner_we      <= sel_we;
                        ram_addr_q    <= win_port ? bus.addr1 : bus.addr0;
                        ram_mdatain_q <= win_port ? bus.wdata1 : bus.wdata0;
                        ram_write_q   <= sel_we;
                        ram_read_q    <= ~sel_we;
                        grant_q       <= port_onehot(win_port);
                        busy_q        <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_read_q  <= 1'b0;
                    ram_write_q <= 1'b0;
                    if (owner_we) begin
                        done0_q <= (owner == PORT_FETCH);
                        done1_q <= (owner == PORT_MEM);
                        grant_q <= 2'b00;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rdata_q <= bus.ram_dout;
                    done0_q <= (owner == PORT_FETCH);
                    done1_q <= (owner == PORT_MEM);
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.done0       = done0_q;
    assign bus.done1       = done1_q;
    assign bus.rdata       = rdata_q;
    assign bus.busy        = busy_q;
    assign bus.grant       = grant_q;
    assign bus.ram_read    = ram_read_q;
    assign bus.ram_write   = ram_write_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_mdatain = ram_mdatain_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench: round-robin and fixed-priority instances, each with its own RAM model.
module tb_ram_access_arbiter;
    import ram_arb_pkg::*;

    logic Clock = 1'b0;
    logic Clear = 1'b0;
    logic load_mem = 1'b1;
    always #5 Clock = ~Clock;

    ram_access_arbiter_if ifa ();
    ram_access_arbiter_if ifb ();

    ram_access_arbiter #(.ADDR_W(9), .DATA_W(32), .RR_EN(1)) dut_rr (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (ifa)
    );

    ram_access_arbiter #(.ADDR_W(9), .DATA_W(32), .RR_EN(0)) dut_fp (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (ifb)
    );

    logic [31:0] mem_a [512];
    logic [31:0] mem_b [512];

    // Sync RAM models: contents start as 0xA5000000 | address.
    always @(posedge Clock) begin
        if (load_mem) begin
            for (int i = 0; i < 512; i++) begin
                mem_a[i] <= 32'hA500_0000 | 32'(i);
                mem_b[i] <= 32'hA500_0000 | 32'(i);
            end
        end else begin
            if (ifa.ram_write) mem_a[ifa.ram_addr] <= ifa.ram_mdatain;
            if (ifa.ram_read)  ifa.ram_dout <= mem_a[ifa.ram_addr];
            if (ifb.ram_write) mem_b[ifb.ram_addr] <= ifb.ram_mdatain;
            if (ifb.ram_read)  ifb.ram_dout <= mem_b[ifb.ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.req0 = 0; ifa.we0 = 0; ifa.addr0 = '0; ifa.wdata0 = '0;
        ifa.req1 = 0; ifa.we1 = 0; ifa.addr1 = '0; ifa.wdata1 = '0;
        ifb.req0 = 0; ifb.we0 = 0; ifb.addr0 = '0; ifb.wdata0 = '0;
        ifb.req1 = 0; ifb.we1 = 0; ifb.addr1 = '0; ifb.wdata1 = '0;
    endtask

    task automatic do_clear();
        idle_inputs();
        Clear = 1;
        tick();
        Clear = 0;
    endtask

    task automatic test_reset();
        ifa.req0 = 1; ifa.req1 = 1; ifb.req0 = 1; ifb.req1 = 1;
        Clear = 1;
        for (int c = 0; c < 2; c++) begin
            tick();
            load_mem = 0;
            checks++;
            if ({ifa.grant, ifa.done0, ifa.done1, ifa.ram_read, ifa.ram_write, ifa.busy} !== 7'b0) begin
                errors++;
                $display("FAIL reset_ctl_rr cycle %0d got %b want 0000000", c,
                         {ifa.grant, ifa.done0, ifa.done1, ifa.ram_read, ifa.ram_write, ifa.busy});
            end
            checks++;
            if (ifa.rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata_rr cycle %0d got %h want 00000000", c, ifa.rdata);
            end
            checks++;
            if ({ifb.grant, ifb.done0, ifb.done1, ifb.ram_read, ifb.ram_write, ifb.busy} !== 7'b0) begin
                errors++;
                $display("FAIL reset_ctl_fp cycle %0d got %b want 0000000", c,
                         {ifb.grant, ifb.done0, ifb.done1, ifb.ram_read, ifb.ram_write, ifb.busy});
            end
            checks++;
            if (ifb.rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata_fp cycle %0d got %h want 00000000", c, ifb.rdata);
            end
        end
        idle_inputs();
        Clear = 0;
        tick();
    endtask

    task automatic test_write_read();
        do_clear();
        ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 9'h005; ifa.wdata1 = 32'hDEADBEEF;
        tick();
        checks++;
        if ({ifa.grant, ifa.busy, ifa.ram_write, ifa.ram_read} !== 5'b10110) begin
            errors++;
            $display("FAIL wr_issue_ctl got %b want 10110", {ifa.grant, ifa.busy, ifa.ram_write, ifa.ram_read});
        end
        checks++;
        if (ifa.ram_addr !== 9'h005 || ifa.ram_mdatain !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_issue_bus got %h/%h want 005/deadbeef", ifa.ram_addr, ifa.ram_mdatain);
        end
        tick();
        checks++;
        if ({ifa.done1, ifa.done0, ifa.grant, ifa.busy, ifa.ram_write} !== 6'b100000) begin
            errors++;
            $display("FAIL wr_done got %b want 100000", {ifa.done1, ifa.done0, ifa.grant, ifa.busy, ifa.ram_write});
        end
        ifa.req1 = 0; ifa.we1 = 0;
        tick();
        checks++;
        if (ifa.done1 !== 1'b0 || mem_a[5] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_after got done1=%b mem=%h want 0/deadbeef", ifa.done1, mem_a[5]);
        end
        ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 9'h005;
        tick();
        checks++;
        if ({ifa.grant, ifa.busy, ifa.ram_read, ifa.ram_write} !== 5'b01110 || ifa.ram_addr !== 9'h005) begin
            errors++;
            $display("FAIL rd_issue got %b addr %h want 01110 addr 005",
                     {ifa.grant, ifa.busy, ifa.ram_read, ifa.ram_write}, ifa.ram_addr);
        end
        tick();
        checks++;
        if ({ifa.done0, ifa.busy, ifa.ram_read} !== 3'b010) begin
            errors++;
            $display("FAIL rd_capture got %b want 010", {ifa.done0, ifa.busy, ifa.ram_read});
        end
        tick();
        checks++;
        if (ifa.done0 !== 1'b1 || ifa.rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_done got done0=%b rdata=%h want 1/deadbeef", ifa.done0, ifa.rdata);
        end
        ifa.req0 = 0;
        tick();
        checks++;
        if ({ifa.done0, ifa.grant} !== 3'b000 || ifa.rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_hold got %b rdata=%h want 000/deadbeef", {ifa.done0, ifa.grant}, ifa.rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [31:0] exp_d;
        do_clear();
        ifa.req0 = 1; ifa.addr0 = 9'h010;
        ifa.req1 = 1; ifa.addr1 = 9'h020;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (k % 2 == 0) ? 32'hA500_0010 : 32'hA500_0020;
            tick();
            checks++;
            if (ifa.grant !== exp_g) begin
                errors++;
                $display("FAIL rr_grant txn %0d got %b want %b", k, ifa.grant, exp_g);
            end
            tick();
            checks++;
            if ({ifa.done1, ifa.done0} !== 2'b00 || ifa.grant !== exp_g) begin
                errors++;
                $display("FAIL rr_capture txn %0d got done=%b grant=%b want 00/%b",
                         k, {ifa.done1, ifa.done0}, ifa.grant, exp_g);
            end
            tick();
            checks++;
            if ({ifa.done1, ifa.done0} !== exp_g || ifa.rdata !== exp_d) begin
                errors++;
                $display("FAIL rr_done txn %0d got done=%b rdata=%h want %b/%h",
                         k, {ifa.done1, ifa.done0}, ifa.rdata, exp_g, exp_d);
            end
            if (k == 3) begin
                ifa.req0 = 0; ifa.req1 = 0;
            end
        end
        tick();
        checks++;
        if ({ifa.grant, ifa.busy} !== 3'b000) begin
            errors++;
            $display("FAIL rr_idle got %b want 000", {ifa.grant, ifa.busy});
        end
    endtask

    task automatic test_fixed_priority();
        do_clear();
        for (int r = 0; r < 3; r++) begin
            ifb.req0 = 1; ifb.addr0 = 9'h010 + 9'(r);
            ifb.req1 = 1; ifb.addr1 = 9'h020;
            tick();
            checks++;
            if (ifb.grant !== 2'b01) begin
                errors++;
                $display("FAIL fp_grant round %0d got %b want 01", r, ifb.grant);
            end
            tick();
            tick();
            checks++;
            if ({ifb.done1, ifb.done0} !== 2'b01 || ifb.rdata !== (32'hA500_0010 + 32'(r))) begin
                errors++;
                $display("FAIL fp_done round %0d got done=%b rdata=%h want 01/%h",
                         r, {ifb.done1, ifb.done0}, ifb.rdata, 32'hA500_0010 + 32'(r));
            end
            ifb.req0 = 0; ifb.req1 = 0;
            tick();
            checks++;
            if ({ifb.grant, ifb.busy} !== 3'b000) begin
                errors++;
                $display("FAIL fp_idle round %0d got %b want 000", r, {ifb.grant, ifb.busy});
            end
        end
        ifb.req1 = 1;
        tick();
        checks++;
        if (ifb.grant !== 2'b10) begin
            errors++;
            $display("FAIL fp_port1_grant got %b want 10", ifb.grant);
        end
        tick();
        tick();
        checks++;
        if (ifb.done1 !== 1'b1 || ifb.rdata !== 32'hA500_0020) begin
            errors++;
            $display("FAIL fp_port1_done got done1=%b rdata=%h want 1/a5000020", ifb.done1, ifb.rdata);
        end
        ifb.req1 = 0;
        tick();
    endtask

    task automatic test_clear_abort();
        do_clear();
        ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 9'h1FF;
        tick();
        tick();
        tick();
        checks++;
        if (ifa.done0 !== 1'b1 || ifa.rdata !== 32'hA500_01FF) begin
            errors++;
            $display("FAIL top_addr_read got done0=%b rdata=%h want 1/a50001ff", ifa.done0, ifa.rdata);
        end
        ifa.req0 = 0;
        tick();
        ifa.req0 = 1; ifa.addr0 = 9'h010;
        tick();
        tick();
        checks++;
        if ({ifa.busy, ifa.done0} !== 2'b10) begin
            errors++;
            $display("FAIL abort_pre got %b want 10", {ifa.busy, ifa.done0});
        end
        Clear = 1; ifa.req0 = 0;
        tick();
        Clear = 0;
        checks++;
        if ({ifa.done0, ifa.busy, ifa.grant} !== 4'b0000 || ifa.rdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_post got %b rdata=%h want 0000/00000000",
                     {ifa.done0, ifa.busy, ifa.grant}, ifa.rdata);
        end
        ifa.req0 = 1; ifa.addr0 = 9'h010;
        ifa.req1 = 1; ifa.we1 = 0; ifa.addr1 = 9'h020;
        tick();
        checks++;
        if (ifa.grant !== 2'b01) begin
            errors++;
            $display("FAIL abort_ptr_reset got %b want 01", ifa.grant);
        end
        tick();
        tick();
        checks++;
        if (ifa.done0 !== 1'b1 || ifa.rdata !== 32'hA500_0010) begin
            errors++;
            $display("FAIL abort_next_done got done0=%b rdata=%h want 1/a5000010", ifa.done0, ifa.rdata);
        end
        ifa.req0 = 0;
        tick();
        checks++;
        if (ifa.grant !== 2'b10) begin
            errors++;
            $display("FAIL abort_pending_grant got %b want 10", ifa.grant);
        end
        tick();
        tick();
        checks++;
        if (ifa.done1 !== 1'b1 || ifa.rdata !== 32'hA500_0020) begin
            errors++;
            $display("FAIL abort_pending_done got done1=%b rdata=%h want 1/a5000020", ifa.done1, ifa.rdata);
        end
        ifa.req1 = 0;
        tick();
    endtask

    task automatic test_addr_hold();
        do_clear();
        ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 9'h010;
        tick();
        checks++;
        if (ifa.ram_addr !== 9'h010 || ifa.ram_read !== 1'b1) begin
            errors++;
            $display("FAIL hold_issue got addr=%h rd=%b want 010/1", ifa.ram_addr, ifa.ram_read);
        end
        ifa.addr0 = 9'h020; ifa.we0 = 1; ifa.wdata0 = 32'h1234_5678;
        tick();
        checks++;
        if (ifa.ram_addr !== 9'h010 || ifa.ram_write !== 1'b0) begin
            errors++;
            $display("FAIL hold_capture got addr=%h wr=%b want 010/0", ifa.ram_addr, ifa.ram_write);
        end
        tick();
        checks++;
        if (ifa.done0 !== 1'b1 || ifa.rdata !== 32'hA500_0010) begin
            errors++;
            $display("FAIL hold_done got done0=%b rdata=%h want 1/a5000010", ifa.done0, ifa.rdata);
        end
        ifa.req0 = 0; ifa.we0 = 0;
        tick();
        checks++;
        if (mem_a[9'h020] !== 32'hA500_0020) begin
            errors++;
            $display("FAIL hold_no_write got %h want a5000020", mem_a[9'h020]);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_fixed_priority();
        test_clear_abort();
        test_addr_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 512 x 32 synchronous RAM. RAM writes take priority over reads; a read returns data registered on the next Clock edge.
- Shares the RAM between port 0 (instruction fetch) and port 1 (MDR load/store).
- Drives the RAM Read/Write/Address/Mdatain lines and captures read data.
- Returns a one-cycle done pulse and the read data to the winning requester.

Parameters:
- ADDR_W, 9, RAM address width (512 words).
- DATA_W, 32, data width.
- RR_EN, 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 wins.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Clear  in  1  reset, synchronous, active-high.
- req0  in  1  port 0 request; level, held until done0.
- we0  in  1  port 0 write enable: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 write data.
- req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  port 1 equivalents.
- done0  out  1  one-cycle completion pulse, port 0.
- done1  out  1  one-cycle completion pulse, port 1.
- rdata  out  DATA_W  read data of the last completed read; valid while done is high.
- busy  out  1  high in ISSUE and CAPTURE.
- grant  out  2  one-hot current owner; 00 when idle.
- ram_read  out  1  RAM Read.
- ram_write  out  1  RAM Write.
- ram_addr  out  ADDR_W  RAM Address.
- ram_mdatain  out  DATA_W  RAM Mdatain.
- ram_dout  in  DATA_W  RAM data_output.

Behaviour:
- All outputs are registered.
- On Clear, the next edge gives:
  - state = IDLE; every output = 0; rr pointer = last-granted port 1, so port 0 wins first.
- State IDLE, at each edge:
  - Eligible requester = reqN high and doneN not high this cycle. A requester drops req in the cycle it sees done; this rule blocks a double grant.
  - No eligible requester: stay in IDLE.
  - Otherwise pick the winner:
    - RR_EN=1, both eligible: the port not last granted wins.
    - RR_EN=0: port 0 wins.
  - Latch the winner's addr/wdata/we; set grant; set ram_write=we or ram_read=!we (never both); go to ISSUE.
- State ISSUE (exactly 1 cycle):
  - RAM samples controls at the closing edge.
  - At that edge, clear ram_read/ram_write.
  - Write: pulse doneN, clear grant, update rr pointer, go to IDLE.
  - Read: go to CAPTURE.
- State CAPTURE (1 cycle):
  - ram_dout is valid.
  - At the closing edge: rdata <= ram_dout, pulse doneN, clear grant, update rr pointer, go to IDLE.
- Latency, counted from the edge sampling req in IDLE:
  - write: done high 2 cycles later;
  - read: done high 3 cycles later.
- Throughput: a new grant is possible on the edge that ends the done cycle. Back-to-back reads = 1 per 3 cycles.
- Boundaries:
  - Address and data are sampled only at grant. Changes to addrN/wdataN/weN while busy are ignored.
  - req from the non-owner while busy is held pending and arbitrated on return to IDLE.
  - rdata holds its value across writes, idle and Clear-free periods. It changes only at read completion (or Clear -> 0).
  - Address 0x1FF is legal. No address wrap or check is needed, since the width matches the RAM.
  - Clear in any state: abort, no done pulse, rr pointer reset.
    - A write whose ISSUE edge coincides with Clear is not guaranteed. The RAM may have stored it, and done is not issued.
  - Simultaneous done for one port and a new req from the other: the other port is eligible in that same IDLE cycle.

Decomposition:
- Shared package ram_arb_pkg holds:
  - state encoding IDLE/ISSUE/CAPTURE;
  - ADDR_W/DATA_W defaults (9/32);
  - port index constants PORT_FETCH=0, PORT_MEM=1.
- One sub-module: rr_arbiter2.
  - Combinational winner select from two eligible bits, the last-grant pointer and RR_EN.
  - Pointer register is updated on completion.

Test Plan:
- Clear held 2 cycles with req0=req1=1 -> grant=00, done0=done1=0, ram_read=ram_write=0, rdata=0, busy=0 throughout.
- Port1 write 0xDEADBEEF to 0x005 -> ram_write=1, ram_addr=0x005 for exactly one cycle; done1 two cycles after sampling. Then port0 reads 0x005 -> rdata=0xDEADBEEF with done0 three cycles after sampling.
- RR_EN=1, both ports read simultaneously and repeatedly -> grant sequence 01,10,01,10. Each done pulses once per transaction, and no port gets two consecutive grants while the other waits.
- RR_EN=0, req0 held through back-to-back reads while req1 high -> port0 wins every arbitration. Port1 is granted only after req0 drops.
- Port0 read of 0x1FF; assert Clear during CAPTURE -> no done0; rdata=0, state IDLE, busy=0 on the next cycle.
- After grant of port0 read at 0x010, change addr0 to 0x020 during ISSUE -> ram_addr stays 0x010, and rdata equals the contents of 0x010.
